// File: rtl/scope_pkg.sv
// Shared types and constants for the scope capture block.
package scope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } state_e;

    localparam logic [1:0] TRIG_RISE = 2'b00;
    localparam logic [1:0] TRIG_FALL = 2'b01;
    localparam logic [1:0] TRIG_BOTH = 2'b10;
    localparam logic [1:0] TRIG_IMM  = 2'b11;

endpackage

// File: rtl/scope_ram.sv
// Simple dual-port sample memory: one write port, registered read port.
// Shaped so that it maps onto iCE40 block RAM.
module scope_ram #(
    parameter int DEPTH = 512,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port and registered read port.
    // NOTE: neither the array nor the read register is reset; a reset would stop block RAM inference, and contents are meant to survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/scope_capture.sv
// Multi-channel triggered capture into a circular buffer with pre-trigger
// history; the frozen window is read back by window index.
// Optional feature macro: SCOPE_AUTO_TRIG_EN (forced trigger after
// AUTO_TIMEOUT samples in WAIT; sets auto_fired).
module scope_capture
    import scope_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 512,
    parameter int PRE          = 128,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       sample_valid,
    input  logic [CHANNELS*WIDTH-1:0]                  sample_in,
    input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0] trig_chan,
    input  logic [WIDTH-1:0]                           trig_level,
    input  logic [1:0]                                 trig_mode,
    input  logic                                       arm,
    input  logic [$clog2(DEPTH)-1:0]                   rd_addr,
    output logic [CHANNELS*WIDTH-1:0]                  rd_data,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       auto_fired
);

    localparam int AW       = $clog2(DEPTH);
    localparam int DW       = CHANNELS * WIDTH;
    localparam int PCW      = $clog2(PRE > 1 ? PRE : 2);
    localparam int POST_LEN = DEPTH - PRE - 1;
    localparam int QCW      = $clog2(POST_LEN > 1 ? POST_LEN : 2);

    if (PRE < 0 || PRE >= DEPTH || AUTO_TIMEOUT < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("scope_capture: invalid parameter combination");
    end

    state_e           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    trig_ptr_q, trig_ptr_d;
    logic [PCW-1:0]   pre_cnt_q, pre_cnt_d;
    logic [QCW-1:0]   post_cnt_q, post_cnt_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] cur;
    logic             wait_sample;
    logic             rise, fall, real_hit, force_trig;
    logic             we;
    logic [AW-1:0]    rd_phys;
    logic [DW-1:0]    ram_rdata;

    // Pick the trigger channel; out-of-range selections fall back to channel 0.
    always_comb begin
        cur = sample_in[0 +: WIDTH];
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(trig_chan) == c) begin
                cur = sample_in[c*WIDTH +: WIDTH];
            end
        end
    end

    assign wait_sample = (state_q == ST_WAIT) && sample_valid && !arm;

    // Evaluate the level-crossing condition for the current WAIT sample.
    always_comb begin
        rise = prev_valid_q && (prev_q < trig_level) && (cur >= trig_level);
        fall = prev_valid_q && (prev_q >= trig_level) && (cur < trig_level);
        case (trig_mode)
            TRIG_RISE: real_hit = wait_sample && rise;
            TRIG_FALL: real_hit = wait_sample && fall;
            TRIG_BOTH: real_hit = wait_sample && (rise || fall);
            default:   real_hit = wait_sample;
        endcase
    end

`ifdef SCOPE_AUTO_TRIG_EN
    localparam int ACW = $clog2(AUTO_TIMEOUT + 1);
    logic [ACW-1:0] auto_cnt_q, auto_cnt_d;
    logic           auto_fired_q, auto_fired_d;

    // Count WAIT samples and force a trigger on the one that reaches the timeout.
    always_comb begin
        auto_cnt_d   = auto_cnt_q;
        auto_fired_d = auto_fired_q;
        force_trig   = 1'b0;
        if (arm || state_q != ST_WAIT) begin
            auto_cnt_d = '0;
        end else if (sample_valid) begin
            auto_cnt_d = auto_cnt_q + 1'b1;
            force_trig = (auto_cnt_q == ACW'(AUTO_TIMEOUT - 1));
        end
        if (arm) begin
            auto_fired_d = 1'b0;
        end else if (force_trig && !real_hit) begin
            auto_fired_d = 1'b1;
        end
    end

    // Auto-trigger counter and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            auto_cnt_q   <= '0;
            auto_fired_q <= 1'b0;
        end else begin
            auto_cnt_q   <= auto_cnt_d;
            auto_fired_q <= auto_fired_d;
        end
    end

    assign auto_fired = auto_fired_q;
`else
    assign force_trig = 1'b0;
    assign auto_fired = 1'b0;
`endif

    // Next-state logic: arming, pre-fill, trigger search and post-fill.
    // NOTE: every signal gets a default at the top so no path leaves one unassigned and a latch is never inferred.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        trig_ptr_d   = trig_ptr_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        we           = 1'b0;
        if (arm) begin
            // arm wins over a coincident sample, which is dropped
            state_d      = (PRE == 0) ? ST_WAIT : ST_PRE;
            pre_cnt_d    = '0;
            post_cnt_d   = '0;
            prev_valid_d = 1'b0;
        end else if (sample_valid) begin
            case (state_q)
                ST_PRE: begin
                    we        = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    pre_cnt_d = pre_cnt_q + 1'b1;
                    if (pre_cnt_q == PCW'(PRE - 1)) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    we           = 1'b1;
                    wr_ptr_d     = wr_ptr_q + 1'b1;
                    prev_d       = cur;
                    prev_valid_d = 1'b1;
                    if (real_hit || force_trig) begin
                        trig_ptr_d = wr_ptr_q;
                        post_cnt_d = '0;
                        state_d    = (POST_LEN == 0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    we         = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_q == QCW'(POST_LEN - 1)) begin
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d == ST_PRE) || (state_d == ST_WAIT) || (state_d == ST_POST);
        done_d = (state_d == ST_DONE);
    end

    // Control state and registered status outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            trig_ptr_q   <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            trig_ptr_q   <= trig_ptr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Window index 0 is PRE samples before the trigger; wraps modulo DEPTH.
    assign rd_phys = trig_ptr_q - AW'(PRE) + rd_addr;

    scope_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (sample_in),
        .raddr (rd_phys),
        .rdata (ram_rdata)
    );

    assign rd_data = done_q ? ram_rdata : '0;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_scope_capture.sv
// Self-checking bench for scope_capture (CHANNELS=2, WIDTH=8, DEPTH=16,
// PRE=4, AUTO_TIMEOUT=32). Honours SCOPE_AUTO_TRIG_EN when defined.
module tb_scope_capture;

    localparam int CHANNELS = 2;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int PRE      = 4;
    localparam int AUTO_TO  = 32;
    localparam int POST_LEN = DEPTH - PRE - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic        trig_chan;
    logic [7:0]  trig_level;
    logic [1:0]  trig_mode;
    logic        arm;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy, done, auto_fired;

    int total = 0;
    int bad   = 0;

    logic [15:0] stim[$];

    scope_capture #(
        .CHANNELS     (CHANNELS),
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .PRE          (PRE),
        .AUTO_TIMEOUT (AUTO_TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .trig_chan    (trig_chan),
        .trig_level   (trig_level),
        .trig_mode    (trig_mode),
        .arm          (arm),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .auto_fired   (auto_fired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] chan_of(input logic [15:0] s, input logic ch);
        return ch ? s[15:8] : s[7:0];
    endfunction

    // Reference: index into stim of the trigger sample, or -1 if none.
    // The first PRE samples are pre-trigger history; the edge comparison
    // needs a previous sample that was itself taken while waiting.
    function automatic int find_trig(input logic ch, input logic [7:0] lvl,
                                     input logic [1:0] mode, output bit forced);
        logic [7:0] cur, prv;
        bit rise, fall;
        forced = 1'b0;
        for (int i = PRE; i < stim.size(); i++) begin
            cur = chan_of(stim[i], ch);
            if (mode == 2'b11) return i;
            if (i > PRE) begin
                prv  = chan_of(stim[i-1], ch);
                rise = (prv < lvl) && (cur >= lvl);
                fall = (prv >= lvl) && (cur < lvl);
                if ((mode == 2'b00 && rise) || (mode == 2'b01 && fall) ||
                    (mode == 2'b10 && (rise || fall))) return i;
            end
`ifdef SCOPE_AUTO_TRIG_EN
            if (i - PRE + 1 == AUTO_TO) begin
                forced = 1'b1;
                return i;
            end
`endif
        end
        return -1;
    endfunction

    // Arm (with a coincident, discarded sample), stream stim, check status
    // every cycle, then read back the whole window. abort_at >= 0 stops
    // after that many samples and leaves the capture running.
    task automatic capture(input string tag, input logic ch, input logic [7:0] lvl,
                           input logic [1:0] mode, input int abort_at);
        int t, last;
        bit forced;
        logic exp_done;
        t    = find_trig(ch, lvl, mode, forced);
        last = (t < 0) ? -1 : t + POST_LEN;
        trig_chan    = ch;
        trig_level   = lvl;
        trig_mode    = mode;
        arm          = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 16'hEEEE;
        tick();
        arm = 1'b0;
        check($sformatf("%s busy_after_arm", tag), busy, 1);
        check($sformatf("%s done_after_arm", tag), done, 0);
        check($sformatf("%s rd_data_after_arm", tag), rd_data, 0);
        check($sformatf("%s auto_after_arm", tag), auto_fired, 0);
        for (int i = 0; i < stim.size(); i++) begin
            if (abort_at >= 0 && i == abort_at) return;
            sample_in = stim[i];
            tick();
            exp_done = (i == last);
            check($sformatf("%s busy@%0d", tag, i), busy, !exp_done);
            check($sformatf("%s done@%0d", tag, i), done, exp_done);
            if (exp_done) break;
        end
        if (last < 0) return;
        check($sformatf("%s auto_fired", tag), auto_fired, forced);
        // keep streaming junk: nothing may be written once frozen
        sample_in = 16'hAAAA;
        tick();
        tick();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = a[3:0];
            tick();
            check($sformatf("%s win[%0d]", tag, a), rd_data, stim[t - PRE + a]);
        end
    endtask

    task automatic read_ch(input string tag, input int a, input logic ch, input logic [7:0] exp);
        rd_addr = a[3:0];
        tick();
        check(tag, chan_of(rd_data, ch), exp);
    endtask

    initial begin
        int  t;
        bit  forced;
        reset        = 1'b1;
        arm          = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        trig_chan    = 1'b0;
        trig_level   = '0;
        trig_mode    = 2'b00;
        rd_addr      = '0;
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset auto", auto_fired, 0);
        check("reset rd_data", rd_data, 0);
        reset = 1'b0;

        // Ramp on ch0 from 0x00, rising through 0x40.
        stim.delete();
        for (int i = 0; i < 300; i++) stim.push_back({8'($urandom), 8'(i)});
        capture("ramp_rise", 1'b0, 8'h40, 2'b00, -1);
`ifndef SCOPE_AUTO_TRIG_EN
        read_ch("ramp_rise lit0", 0, 1'b0, 8'h3C);
        read_ch("ramp_rise lit4", 4, 1'b0, 8'h40);
        read_ch("ramp_rise lit15", 15, 1'b0, 8'h4B);
`endif

        // Ramp from 0x3E: the crossing inside pre-fill must be ignored.
        stim.delete();
        for (int i = 0; i < 300; i++) stim.push_back({8'($urandom), 8'(8'h3E + i)});
        capture("ramp_wrap", 1'b0, 8'h40, 2'b00, -1);
`ifndef SCOPE_AUTO_TRIG_EN
        read_ch("ramp_wrap lit4", 4, 1'b0, 8'h40);
        read_ch("ramp_wrap lit3", 3, 1'b0, 8'h3F);
`endif

        // Square on ch1, falling through 0x80.
        stim.delete();
        for (int i = 0; i < 64; i++) stim.push_back({((i % 8) < 4) ? 8'hF0 : 8'h10, 8'($urandom)});
        capture("square_fall", 1'b1, 8'h80, 2'b01, -1);
        read_ch("square_fall lit4", 4, 1'b1, 8'h10);
        read_ch("square_fall lit3", 3, 1'b1, 8'hF0);

        // Random data, either edge on ch1, random level.
        stim.delete();
        for (int i = 0; i < 60; i++) stim.push_back(16'($urandom));
        capture("rand_both", 1'b1, 8'($urandom_range(32, 224)), 2'b10, -1);

        // Random data, immediate mode on ch0.
        stim.delete();
        for (int i = 0; i < 30; i++) stim.push_back(16'($urandom));
        capture("rand_imm", 1'b0, 8'($urandom), 2'b11, -1);

        // Reset (together with arm) in the middle of POST.
        stim.delete();
        for (int i = 0; i < 64; i++) stim.push_back({((i % 8) < 4) ? 8'hF0 : 8'h10, 8'($urandom)});
        t = find_trig(1'b1, 8'h80, 2'b01, forced);
        capture("reset_post", 1'b1, 8'h80, 2'b01, t + 3);
        check("reset_post in_post busy", busy, 1);
        reset = 1'b1;
        arm   = 1'b1;
        tick();
        check("reset_post busy", busy, 0);
        check("reset_post done", done, 0);
        check("reset_post rd_data", rd_data, 0);
        reset = 1'b0;
        arm   = 1'b0;
        tick();
        check("reset_post idle busy", busy, 0);
        capture("after_reset", 1'b1, 8'h80, 2'b01, -1);

        // Re-arm while waiting; the coincident sample is dropped.
        stim.delete();
        for (int i = 0; i < 100; i++) stim.push_back(16'h0000);
        capture("wait_abort", 1'b0, 8'h40, 2'b00, 10);
        stim.delete();
        for (int i = 0; i < 60; i++) stim.push_back({8'($urandom), 8'(8'h30 + i)});
        capture("rearm", 1'b0, 8'h40, 2'b00, -1);

        // Constant zero input: only the auto trigger can end WAIT.
        stim.delete();
        for (int i = 0; i < 1000; i++) stim.push_back(16'h0000);
        capture("auto", 1'b0, 8'h40, 2'b00, -1);
`ifndef SCOPE_AUTO_TRIG_EN
        check("auto never_done", done, 0);
        check("auto flag_off", auto_fired, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scope_capture.md
# scope_capture

Multi-channel triggered sample capture for the scope display path. It records up to CHANNELS parallel sample streams into a circular buffer with pre-trigger history and fires on a programmable level crossing. It then freezes a DEPTH-sample window that the waveform renderer reads by x-pixel address, one clock per read. It sits in the vga_clk domain, between the sample source (strobed by sample_valid) and the waveform drawing block.

## Interface
- CHANNELS, 2: number of parallel sample channels (≥1).
- WIDTH, 8: bits per sample.
- DEPTH, 512: capture window length, power of two, ≥ display trace width.
- PRE, 128: pre-trigger samples, 0 ≤ PRE < DEPTH.
- AUTO_TIMEOUT, 65535: samples spent in WAIT before a forced trigger (used only with SCOPE_AUTO_TRIG_EN).
- clk  in  1  capture/read clock (vga_clk). One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_in  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- trig_chan  in  max(1,clog2(CHANNELS))  channel compared against trig_level.
- trig_level  in  WIDTH  unsigned trigger threshold.
- trig_mode  in  2  00 rising, 01 falling, 10 either edge, 11 immediate.
- arm  in  1  single-cycle pulse that starts a capture.
- rd_addr  in  clog2(DEPTH)  window index; 0 is oldest, PRE is the trigger sample.
- rd_data  out  CHANNELS*WIDTH  window sample at rd_addr.
- busy  out  1  state is PRE, WAIT or POST.
- done  out  1  a window is frozen and readable.
- auto_fired  out  1  the last capture was force-triggered.

## Operation
- States are IDLE, PRE, WAIT, POST and DONE. Reset enters IDLE.
- IDLE or DONE, arm goes to PRE. If PRE is 0, arm goes straight to WAIT.
- PRE: each sample_valid writes at wr_ptr and increments wr_ptr modulo DEPTH. After PRE writes the state moves to WAIT. The trigger is not evaluated in PRE.
- WAIT: each sample is written. prev holds the last trig_chan sample and is valid after at least one sample.
  - Rising fires when prev < level and cur ≥ level.
  - Falling fires when prev ≥ level and cur < level.
  - Either edge fires on rising or falling.
  - Immediate fires on the first WAIT sample.
- On a trigger, trig_ptr is set to the address of the trigger sample and the state moves to POST.
- POST: after DEPTH-PRE-1 further writes the state moves to DONE. Writes then stop.
- Window mapping: physical address = (trig_ptr − PRE + rd_addr) mod DEPTH.
- rd_data is 0 in every state except DONE.
- arm in PRE, WAIT or POST restarts at PRE. Memory is not cleared.
- arm and sample_valid in the same cycle: arm wins and the sample is discarded.
- reset and arm in the same cycle: reset wins.
- prev_valid clears on arm and on reset.
- trig_chan ≥ CHANNELS selects channel 0.
- Reset in any state: state goes to IDLE; wr_ptr, trig_ptr, prev and prev_valid clear. Memory is retained.
- Reset values of outputs: rd_data = 0, busy = 0, done = 0, auto_fired = 0.
- done clears on arm and on reset.

## Timing
- arm sampled at edge n: busy = 1 from n+1. The first writable sample is at edge n+1.
- A trigger sample at edge t: state is POST at t+1.
- The final POST write at edge f: done = 1 and busy = 0 from f+1.
- Read latency is exactly 1 clock, registered: rd_addr at edge k gives rd_data after edge k+1.
- Trigger controls (trig_chan, trig_level, trig_mode) are sampled with each sample. Changes take effect on the next sample_valid.

## Configuration
- SCOPE_AUTO_TRIG_EN defined: a WAIT sample counter runs. When it reaches AUTO_TIMEOUT it forces a trigger on that sample and sets auto_fired = 1. The counter clears on entry to WAIT.
- SCOPE_AUTO_TRIG_EN undefined: WAIT lasts until a real trigger. auto_fired is tied to 0 and the counter is not synthesised.

## Structure
- Package scope_pkg holds:
  - the state enum;
  - the trig_mode constants TRIG_RISE, TRIG_FALL, TRIG_BOTH and TRIG_IMM.
- Sub-module scope_ram: simple dual-port memory, DEPTH × CHANNELS*WIDTH, one write port, registered read. It infers iCE40 BRAM.

## Test plan
Bench parameters: CHANNELS = 2, WIDTH = 8, DEPTH = 16, PRE = 4, sample_valid every cycle.
- Ramp ch0 from 0x00 step 1, trig_level 0x40, rising, arm → done. Reading rd_addr 0..15 gives ch0 = 0x3C..0x4B, with rd_addr 4 = 0x40.
- Ramp starting at 0x3E, rising, level 0x40 → the 0x40 crossing falls inside PRE and is ignored. No trigger occurs until the wrapped ramp reaches 0x40 again, 256 samples later.
- ch1 square 0xF0/0x10 with period 8, trig_chan 1, falling, level 0x80 → rd_addr 4 has ch1 = 0x10 and rd_addr 3 has ch1 = 0xF0.
- Reset asserted mid-POST → the next cycle shows busy = 0, done = 0, rd_data = 0. A new arm then completes normally.
- arm during WAIT, and arm coinciding with sample_valid → the capture restarts at PRE. The coincident sample does not appear in the window.
- Constant 0x00 input, rising, AUTO_TIMEOUT = 32:
  - with SCOPE_AUTO_TRIG_EN: done and auto_fired = 1 after 4 + 32 + 11 samples;
  - without it: done = 0 after 1000 samples.
